alu_muldiv_unit: RTL
====================

// Module: alu_muldiv_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit for the execute stage (RV32M ops).
//  Sits beside the single-cycle ALU; the stage routes M-extension ops here and stalls on busy.
//  Radix-2 shift-add multiply and restoring divide, one bit per cycle, XLEN-parametrised.
//  Valid/ready handshake on both sides; flush aborts an in-flight op on pipeline redirect.
// PARAMETERS
//  XLEN     32   operand/result width in bits (>=8)
// PORTS
//  clk         in   1     clock, rising edge
//  reset       in   1     synchronous, active-high
//  flush       in   1     synchronous abort of any op in flight
//  in_valid    in   1     op/a/b valid this cycle
//  in_ready    out  1     unit can accept an op (state IDLE)
//  op          in   3     funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  a           in   XLEN  rs1 operand (multiplicand / dividend)
//  b           in   XLEN  rs2 operand (multiplier / divisor)
//  out_valid   out  1     result valid; held until accepted
//  out_ready   in   1     consumer accepts result
//  result      out  XLEN  result; stable while out_valid=1
//  busy        out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, result=0; all internal regs cleared.
//  Priority per cycle: reset > flush > normal operation.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE; special-case path IDLE -> DONE.
//  IDLE: in_ready=1. Accept on in_valid&&in_ready (cycle T): latch op, sign flags, magnitudes.
//   Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
//   Magnitude = two's-complement negate if operand treated signed and MSB=1 (MIN stays MIN, read unsigned).
//  Special cases, detected at accept, go to DONE at T+1 (out_valid from T+1):
//   b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   signed overflow (a==MIN, b==-1): DIV -> MIN; REM -> 0.
//  CALC: exactly XLEN cycles, counter XLEN-1 down to 0, wraps to FIX.
//   Multiply: 2*XLEN accumulator; each cycle add multiplicand<<i if multiplier bit i set.
//   Divide: restoring; shift remainder left, subtract divisor, set quotient bit if non-negative.
//  FIX (1 cycle): apply sign. Product negated (2*XLEN wide) if operand signs differ.
//   Quotient negated if signs differ; remainder takes dividend's sign.
//   MUL -> low XLEN bits; MULH/MULHSU/MULHU -> high XLEN bits.
//  DONE: out_valid=1, result registered. Normal latency: out_valid first high at T+XLEN+2.
//   out_valid&&out_ready -> IDLE next cycle; no same-cycle re-accept (in_ready=0 in DONE).
//   out_ready=0: hold out_valid and result indefinitely, unchanged.
//  flush in any state: -> IDLE next cycle, out_valid=0, result not delivered, in_ready=1 next cycle.
//   flush in IDLE with in_valid=1: op is NOT accepted.
//  reset mid-op: identical to reset values above next cycle; no partial result visible.
//  in_valid while busy is ignored; a/b/op may change freely after acceptance.
//  All arithmetic modulo 2^XLEN (result) / 2^(2*XLEN) (product); no exceptions raised.
// TESTING
//  MUL a=7 b=0xFFFFFFFD accept T -> out_valid at T+34, result=0xFFFFFFEB; MULHU same -> 0x00000006.
//  MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
//  DIVU 100/7 -> 14, REMU -> 2; DIV -100/7 -> 0xFFFFFFF2 (-14), REM -> 0xFFFFFFFE (-2), at T+34.
//  DIV a=5 b=0 -> 0xFFFFFFFF at T+1; REM -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, at T+1.
//  out_ready=0 for 5 cycles in DONE -> out_valid and result stable; then handshake -> in_ready at next cycle.
//  flush at CALC cycle 10 -> IDLE next cycle, no out_valid ever; reset mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with valid/ready handshakes and pipeline flush.
module alu_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_sa, r_sb;
  logic [CW-1:0]   r_cnt;
  logic [W2-1:0]   r_mcand;
  logic [W2-1:0]   r_acc;
  logic [XLEN-1:0] r_mplier;   // multiplier (shifted right) or divisor (held)
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;      // dividend bits shift out as quotient bits shift in
  logic [XLEN-1:0] r_result;
  logic            r_out_valid, r_in_ready, r_busy;

  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;
  logic [W2-1:0]   w_acc_add;
  logic [XLEN:0]   w_rem_sh, w_rem_sub;
  logic [W2-1:0]   w_prod;
  logic [XLEN-1:0] w_quo_s, w_rem_s, w_fix_res;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_MULHSU: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg = w_a_signed & a[XLEN-1];
  assign w_b_neg = w_b_signed & b[XLEN-1];
  assign w_a_mag = w_a_neg ? (~a + XLEN'(1)) : a;
  assign w_b_mag = w_b_neg ? (~b + XLEN'(1)) : b;

  assign w_div_zero = op[2] && (b == '0);
  assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN) && (b == '1);
  assign w_special  = w_div_zero || w_ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = op[1] ? a : '1;
    else if (w_ovf)
      w_special_res = op[1] ? '0 : MIN;
  end

  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_mplier};

  assign w_prod  = (r_sa ^ r_sb) ? (~r_acc + W2'(1)) : r_acc;
  assign w_quo_s = (r_sa ^ r_sb) ? (~r_quo + XLEN'(1)) : r_quo;
  assign w_rem_s = r_sa ? (~r_rem + XLEN'(1)) : r_rem;

  always_comb begin
    w_fix_res = w_rem_s;
    case (r_op)
      OP_MUL:                     w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[W2-1:XLEN];
      OP_DIV, OP_DIVU:            w_fix_res = w_quo_s;
      default:                    w_fix_res = w_rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= op;
            r_sa       <= w_a_neg;
            r_sb       <= w_b_neg;
            r_cnt      <= CW'(XLEN - 1);
            r_mcand    <= {{XLEN{1'b0}}, w_a_mag};
            r_acc      <= '0;
            r_mplier   <= w_b_mag;
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_special) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            if (!w_rem_sub[XLEN]) begin
              r_rem <= w_rem_sub[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b1};
            end else begin
              r_rem <= w_rem_sh[XLEN-1:0];
              r_quo <= {r_quo[XLEN-2:0], 1'b0};
            end
          end else begin
            r_acc    <= w_acc_add;
            r_mcand  <= {r_mcand[W2-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          end
          if (r_cnt == '0)
            r_state <= S_FIX;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_result    <= w_fix_res;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule
